sample_handoff_fifo: RTL and testbench



---
 rtl/sample_fifo_pkg.sv | 16 +
 rtl/sample_fifo_mem.sv | 25 ++
 rtl/sample_handoff_fifo.sv | 97 +++++++++
 tb/tb_sample_handoff_fifo.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sample_fifo_pkg.sv
// Shared defaults and helpers for the sample handoff FIFO.
// Optional build macro used by the top level: SYNC_FIFO_OVERWRITE_EN.
package sample_fifo_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;

  // Pointer width for a power-of-two depth.
  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer type for the default depth.
  typedef logic [calc_aw(DEF_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/sample_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one
// combinational read port. Contents are never reset.
module sample_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sample_handoff_fifo.sv
// Single-clock sample FIFO with registered output word, occupancy and
// sticky overflow/underflow flags.
// Build option SYNC_FIFO_OVERWRITE_EN: a write into a full FIFO (no read
// that cycle) replaces the oldest entry instead of being dropped.
module sample_handoff_fifo
  import sample_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      write_en,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      read_en,
  output logic [WIDTH-1:0]          data_out,
  output logic                      empty,
  output logic                      full,
  output logic [calc_aw(DEPTH):0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = calc_aw(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] addr_t;

  addr_t            wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             wr_ok, rd_ok, ovr_wr, mem_we;

  // A read in the same cycle frees a slot, so a full FIFO still accepts
  // the write. An empty FIFO never forwards the incoming word.
  assign wr_ok = write_en && (!full || read_en);
  assign rd_ok = read_en && !empty;

`ifdef SYNC_FIFO_OVERWRITE_EN
  assign ovr_wr = write_en && full && !read_en;
`else
  assign ovr_wr = 1'b0;
`endif

  assign mem_we = wr_ok || ovr_wr;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  sample_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Pointer advance; an overwrite drops the oldest entry by moving rd_ptr too.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (mem_we)          wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok || ovr_wr) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: only a lone write or a lone read changes it.
  always_ff @(posedge clk) begin
    if (reset)                count <= '0;
    else if (wr_ok && !rd_ok) count <= count + 1'b1;
    else if (rd_ok && !wr_ok) count <= count - 1'b1;
  end

  // Output word holds until the next accepted read.
  always_ff @(posedge clk) begin
    if (reset)      data_out <= '0;
    else if (rd_ok) data_out <= rdata;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && full && !read_en) overflow  <= 1'b1;
      if (read_en && empty)             underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_handoff_fifo.sv
// Directed bench for sample_handoff_fifo with a queue-based reference model.
module tb_sample_handoff_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             write_en = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             read_en = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             empty, full, overflow, underflow;
  logic [2:0]       count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  sample_handoff_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .write_en  (write_en),
    .data_in   (data_in),
    .read_en   (read_en),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of pending words.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      if (read_en) begin
        if (q.size() > 0) m_dout = q.pop_front();
        else              m_unf  = 1'b1;
      end
      if (write_en) begin
        if (q.size() < DEPTH) q.push_back(data_in);
        else begin
          m_ovf = 1'b1;
`ifdef SYNC_FIFO_OVERWRITE_EN
          void'(q.pop_front());
          q.push_back(data_in);
`endif
        end
      end
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // Every cycle once the first reset has completed.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_data_out",  data_out, m_dout);
      chk("m_count",     32'(count), 32'(q.size()));
      chk("m_empty",     32'(empty), 32'(q.size() == 0));
      chk("m_full",      32'(full), 32'(q.size() == DEPTH));
      chk("m_overflow",  32'(overflow), 32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_unf));
    end
  end

  task automatic cyc(input bit we, input logic [WIDTH-1:0] d, input bit re);
    write_en = we;
    data_in  = d;
    read_en  = re;
    @(negedge clk);
  endtask

  task automatic fill4();
    cyc(1, 32'h11111111, 0);
    cyc(1, 32'h22222222, 0);
    cyc(1, 32'h33333333, 0);
    cyc(1, 32'h44444444, 0);
  endtask

  logic [WIDTH-1:0] exp_v [4];

  initial begin
    // Reset for two cycles
    reset = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk_en = 1'b1;
    chk("rst_dout", data_out, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);
    reset = 1'b0;

    // Fill and drain
    fill4();
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    cyc(0, 0, 1); chk("drain0", data_out, 32'h11111111);
    cyc(0, 0, 1); chk("drain1", data_out, 32'h22222222);
    cyc(0, 0, 1); chk("drain2", data_out, 32'h33333333);
    cyc(0, 0, 1); chk("drain3", data_out, 32'h44444444);
    chk("drain_empty", 32'(empty), 32'd1);

    // Read while empty: output holds, underflow latches
    cyc(0, 0, 1);
    chk("unf_hold", data_out, 32'h44444444);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    cyc(0, 0, 0);
    chk("unf_sticky", 32'(underflow), 32'd1);

    // Overflow
    reset = 1'b1; cyc(0, 0, 0); reset = 1'b0;
    fill4();
    cyc(1, 32'h55555555, 0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
`ifdef SYNC_FIFO_OVERWRITE_EN
    exp_v[0] = 32'h22222222; exp_v[1] = 32'h33333333;
    exp_v[2] = 32'h44444444; exp_v[3] = 32'h55555555;
`else
    exp_v[0] = 32'h11111111; exp_v[1] = 32'h22222222;
    exp_v[2] = 32'h33333333; exp_v[3] = 32'h44444444;
`endif
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1);
      chk("ovf_drain", data_out, exp_v[i]);
    end

    // Simultaneous read+write while full
    fill4();
    cyc(1, 32'hAAAAAAAA, 1);
    chk("sim_full_count", 32'(count), 32'd4);
    chk("sim_full_dout", data_out, 32'h11111111);
    cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1);
    chk("sim_full_pre", data_out, 32'h44444444);
    cyc(0, 0, 1);
    chk("sim_full_last", data_out, 32'hAAAAAAAA);

    // Simultaneous read+write while empty: no fall-through
    reset = 1'b1; cyc(0, 0, 0); reset = 1'b0;
    cyc(1, 32'hBBBBBBBB, 1);
    chk("sim_empty_count", 32'(count), 32'd1);
    chk("sim_empty_unf", 32'(underflow), 32'd1);
    chk("sim_empty_dout", data_out, 32'h0);
    cyc(0, 0, 1);
    chk("sim_empty_read", data_out, 32'hBBBBBBBB);

    // Interleaved traffic across the pointer wrap
    reset = 1'b1; cyc(0, 0, 0); reset = 1'b0;
    cyc(1, 32'd1, 0);
    for (int i = 2; i <= 10; i++) begin
      cyc(1, 32'(i), 1);
      chk("wrap_dout", data_out, 32'(i - 1));
      chk("wrap_count", 32'(count), 32'd1);
    end
    cyc(0, 0, 1);
    chk("wrap_last", data_out, 32'd10);

    // Mid-operation reset wins over simultaneous write/read
    cyc(1, 32'hC0, 0); cyc(1, 32'hC1, 0); cyc(1, 32'hC2, 0);
    chk("mid_count3", 32'(count), 32'd3);
    reset = 1'b1;
    cyc(1, 32'hC3, 1);
    reset = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_dout", data_out, 32'h0);
    cyc(1, 32'hD0, 0);
    cyc(0, 0, 1);
    chk("post_rst_read", data_out, 32'hD0);
    cyc(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
